// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue: levels 0-1 in registers, deeper levels in sibling-pair RAMs; max-ordered unless BRAM_HEAP_MIN_ORDER_EN is defined.
// Latency: enqueue/replace busy 2*(LEVELS-1) cycles, dequeue one more; o_size/o_empty/o_full update on the accept edge.
// Backpressure: commands are taken only while o_ready=1; commands while busy, deq-when-empty and enq-when-full are dropped.
module bram_heap_pq #(
    parameter int LEVELS     = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_wrt,
    input  logic                  i_read,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [LEVELS-1:0]     o_size
);

    localparam int DW         = DATA_WIDTH;
    localparam int QUEUE_SIZE = 2**LEVELS - 1;
    localparam int LVW        = $clog2(LEVELS);
    localparam logic [LVW-1:0] LAST = LVW'(LEVELS - 1);

    typedef enum logic [1:0] {IDLE, FETCH_LAST, RD, CMP} state_t;

    state_t            state, nstate;
    logic [LEVELS-1:0] size, tgt, po;
    logic [LVW-1:0]    lvl, tdep;
    logic [DW-1:0]     root, key;
    logic [DW-1:0]     l1 [2];
    logic              sift, done, fpend;
    logic [2*DW-1:0]   par_pair;
    logic [2*DW-1:0]   lvl_q [LEVELS];

    logic              acc_enq, acc_rep, acc_deq;
    logic [LEVELS-1:0] fidx1, foff, poff;
    logic [LVW-1:0]    fdep;
    logic [DW-1:0]     fetched, node_v, best_v, pv;
    logic [2*DW-1:0]   rp;
    logic [LEVELS:0]   cl_idx;
    logic              vl, vr, best_h, child_win;

    logic              rd_en, wa_en, wb_en;
    logic [LVW-1:0]    rd_lvl, wa_lvl, wb_lvl;
    logic [LEVELS-1:0] rd_addr, wa_addr, wb_addr;
    logic [2*DW-1:0]   wa_word, wb_word;
    logic              root_we, l1_we, l1_wi, key_we, child_mv, sift_stop;
    logic [DW-1:0]     root_wd, l1_wd, key_wd;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef BRAM_HEAP_MIN_ORDER_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    function automatic logic [LVW-1:0] flog2(input logic [LEVELS-1:0] v);
        logic [LVW-1:0] r;
        r = '0;
        for (int i = 1; i < LEVELS; i++)
            if (v[i]) r = LVW'(i);
        return r;
    endfunction

    function automatic logic [DW-1:0] get_half(input logic [2*DW-1:0] w, input logic h);
        return h ? w[2*DW-1:DW] : w[DW-1:0];
    endfunction

    function automatic logic [2*DW-1:0] put_half(input logic [2*DW-1:0] w, input logic h,
                                                 input logic [DW-1:0] v);
        return h ? {v, w[DW-1:0]} : {w[2*DW-1:DW], v};
    endfunction

    // One RAM per level >= 2, one word per sibling pair {odd, even}
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        if (l >= 2) begin : g_ram
            logic [2*DW-1:0] mem [2**(l-1)];
            logic [2*DW-1:0] q;
            always_ff @(posedge CLK) begin
                if (wa_en && wa_lvl == LVW'(l))
                    mem[wa_addr[l-2:0]] <= wa_word;
                else if (wb_en && wb_lvl == LVW'(l))
                    mem[wb_addr[l-2:0]] <= wb_word;
                if (rd_en && rd_lvl == LVW'(l))
                    q <= mem[rd_addr[l-2:0]];
            end
            assign lvl_q[l] = q;
        end else begin : g_reg
            assign lvl_q[l] = '0;
        end
    end

    always_comb begin
        acc_enq = (state == IDLE) && i_wrt && (!i_read || size == '0)
                  && (size != LEVELS'(QUEUE_SIZE));
        acc_rep = (state == IDLE) && i_wrt && i_read && (size != '0);
        acc_deq = (state == IDLE) && i_read && !i_wrt && (size != '0);

        fidx1 = size + LEVELS'(1);
        fdep  = flog2(fidx1);
        foff  = fidx1 ^ (LEVELS'(1) << fdep);
        if (fdep == '0)
            fetched = root;
        else if (fdep == LVW'(1))
            fetched = l1[foff[0]];
        else
            fetched = get_half(lvl_q[fdep], foff[0]);

        // Insertion path node at this level, taken from the bits of target+1
        poff   = (tgt >> (tdep - lvl)) ^ (LEVELS'(1) << lvl);
        rp     = (lvl == LVW'(1)) ? {l1[1], l1[0]} : lvl_q[lvl];
        node_v = get_half(rp, poff[0]);

        cl_idx    = ((LEVELS+1)'(1) << lvl) - (LEVELS+1)'(1) + {po, 1'b0};
        vl        = cl_idx < {1'b0, size};
        vr        = (cl_idx + (LEVELS+1)'(1)) < {1'b0, size};
        best_h    = vr && better(rp[2*DW-1:DW], rp[DW-1:0]);
        best_v    = get_half(rp, best_h);
        child_win = vl && better(best_v, key);
        pv        = child_win ? best_v : key;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        rd_en     = 1'b0;  rd_lvl  = '0;  rd_addr = '0;
        wa_en     = 1'b0;  wa_lvl  = '0;  wa_addr = '0;  wa_word = '0;
        wb_en     = 1'b0;  wb_lvl  = '0;  wb_addr = '0;  wb_word = '0;
        root_we   = 1'b0;  root_wd = '0;
        l1_we     = 1'b0;  l1_wi   = 1'b0; l1_wd  = '0;
        key_we    = 1'b0;  key_wd  = '0;
        child_mv  = 1'b0;  sift_stop = 1'b0;
        case (state)
            IDLE: begin
                if (acc_deq)
                    nstate = FETCH_LAST;
                else if (acc_enq || acc_rep)
                    nstate = RD;
            end
            FETCH_LAST: begin
                nstate = RD;
                if (fdep >= LVW'(2)) begin
                    rd_en   = 1'b1;
                    rd_lvl  = fdep;
                    rd_addr = foff >> 1;
                end
            end
            RD: begin
                nstate = CMP;
                if (lvl >= LVW'(2) && (sift || lvl <= tdep)) begin
                    rd_en   = 1'b1;
                    rd_lvl  = lvl;
                    rd_addr = sift ? po : (poff >> 1);
                end
            end
            CMP: begin
                nstate = (lvl == LAST) ? IDLE : RD;
                if (!sift) begin
                    // Winner stays at the path node, loser is carried further down
                    if (lvl == tdep || (lvl < tdep && better(key, node_v))) begin
                        if (lvl != tdep) begin
                            key_we = 1'b1;
                            key_wd = node_v;
                        end
                        if (lvl == LVW'(1)) begin
                            l1_we = 1'b1;  l1_wi = poff[0];  l1_wd = key;
                        end else begin
                            wb_en   = 1'b1;
                            wb_lvl  = lvl;
                            wb_addr = poff >> 1;
                            wb_word = put_half(rp, poff[0], key);
                        end
                    end
                end else if (!done) begin
                    if (lvl == LVW'(1)) begin
                        root_we = 1'b1;  root_wd = pv;
                    end else if (lvl == LVW'(2)) begin
                        l1_we = 1'b1;  l1_wi = po[0];  l1_wd = pv;
                    end else begin
                        wa_en   = 1'b1;
                        wa_lvl  = lvl - LVW'(1);
                        wa_addr = po >> 1;
                        wa_word = put_half(par_pair, po[0], pv);
                    end
                    if (child_win) begin
                        child_mv = 1'b1;
                        // Bottom level reached while still sinking: park the key in the leaf
                        if (lvl == LAST) begin
                            if (lvl == LVW'(1)) begin
                                l1_we = 1'b1;  l1_wi = best_h;  l1_wd = key;
                            end else begin
                                wb_en   = 1'b1;
                                wb_lvl  = lvl;
                                wb_addr = po;
                                wb_word = put_half(rp, best_h, key);
                            end
                        end
                    end else begin
                        sift_stop = 1'b1;
                    end
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            size     <= '0;
            root     <= '0;
            key      <= '0;
            l1[0]    <= '0;
            l1[1]    <= '0;
            tgt      <= '0;
            tdep     <= '0;
            po       <= '0;
            lvl      <= '0;
            sift     <= 1'b0;
            done     <= 1'b0;
            fpend    <= 1'b0;
            par_pair <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lvl  <= LVW'(1);
                    po   <= '0;
                    done <= 1'b0;
                    if (acc_enq) begin
                        size <= size + LEVELS'(1);
                        tgt  <= fidx1;
                        tdep <= fdep;
                        sift <= 1'b0;
                        if (size == '0) begin
                            root <= i_data;
                        end else if (better(i_data, root)) begin
                            root <= i_data;
                            key  <= root;
                        end else begin
                            key  <= i_data;
                        end
                    end else if (acc_rep) begin
                        key  <= i_data;
                        sift <= 1'b1;
                    end else if (acc_deq) begin
                        size  <= size - LEVELS'(1);
                        sift  <= 1'b1;
                        fpend <= 1'b1;
                    end
                end
                RD: begin
                    if (fpend) begin
                        key   <= fetched;
                        fpend <= 1'b0;
                    end
                end
                CMP: begin
                    if (root_we)   root      <= root_wd;
                    if (l1_we)     l1[l1_wi] <= l1_wd;
                    if (key_we)    key       <= key_wd;
                    if (child_mv)  po        <= {po[LEVELS-2:0], best_h};
                    if (sift_stop) done      <= 1'b1;
                    par_pair <= rp;
                    if (lvl != LAST) lvl <= lvl + LVW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_empty = (size == '0);
    assign o_full  = (size == LEVELS'(QUEUE_SIZE));
    assign o_data  = o_empty ? '0 : root;
    assign o_size  = size;

endmodule

// File: tb/tb_bram_heap_pq.sv
// Randomised bench for bram_heap_pq against a multiset model of the queue contents.
module tb_bram_heap_pq;
    localparam int LEVELS = 4;
    localparam int DW     = 16;
    localparam int QS     = 2**LEVELS - 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              i_wrt, i_read;
    logic [DW-1:0]     i_data;
    logic              o_ready, o_full, o_empty;
    logic [DW-1:0]     o_data;
    logic [LEVELS-1:0] o_size;

    always #5 CLK = ~CLK;

    bram_heap_pq #(.LEVELS(LEVELS), .DATA_WIDTH(DW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .i_wrt  (i_wrt),
        .i_read (i_read),
        .i_data (i_data),
        .o_ready(o_ready),
        .o_full (o_full),
        .o_empty(o_empty),
        .o_data (o_data),
        .o_size (o_size)
    );

    int unsigned mdl[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int unsigned mdl_top();
        int unsigned t;
        if (mdl.size() == 0) return 0;
        t = mdl[0];
        foreach (mdl[i]) begin
`ifdef BRAM_HEAP_MIN_ORDER_EN
            if (mdl[i] < t) t = mdl[i];
`else
            if (mdl[i] > t) t = mdl[i];
`endif
        end
        return t;
    endfunction

    function automatic void mdl_pop();
        int unsigned t;
        t = mdl_top();
        for (int i = 0; i < mdl.size(); i++) begin
            if (mdl[i] == t) begin
                mdl.delete(i);
                break;
            end
        end
    endfunction

    // Issue one command at a negedge, measure busy time, then compare with the model
    task automatic op(input logic w, input logic r, input int unsigned d, input logic glitch,
                      input string tag);
        int unsigned dv;
        int          busy, exp_busy;
        bit          rep, enq, deq;
        dv  = d & ((1 << DW) - 1);
        rep = w && r && mdl.size() != 0;
        enq = w && !rep && mdl.size() < QS;
        deq = r && !w && mdl.size() != 0;
        exp_busy = deq ? 2*(LEVELS-1) + 1 : (rep || enq) ? 2*(LEVELS-1) : 0;
        i_wrt  = w;
        i_read = r;
        i_data = DW'(dv);
        @(posedge CLK);
        #1;
        i_wrt  = 1'b0;
        i_read = 1'b0;
        if (rep) mdl_pop();
        if (deq) mdl_pop();
        if (rep || enq) mdl.push_back(dv);
        busy = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK);
            if (o_ready) break;
            if (glitch && k == 0) begin
                i_wrt  = 1'b1;
                i_read = 1'($urandom_range(0, 1));
                i_data = DW'($urandom);
            end else begin
                i_wrt  = 1'b0;
                i_read = 1'b0;
            end
            @(posedge CLK);
            busy++;
        end
        i_wrt  = 1'b0;
        i_read = 1'b0;
        chk({tag, ".busy"},  busy,    exp_busy);
        chk({tag, ".data"},  o_data,  mdl_top());
        chk({tag, ".size"},  o_size,  mdl.size());
        chk({tag, ".empty"}, o_empty, mdl.size() == 0);
        chk({tag, ".full"},  o_full,  mdl.size() == QS);
    endtask

    initial begin
        int unsigned dir_keys[5];
        int unsigned dir_exp[5];
        int          cmd;
        RST    = 1'b1;
        i_wrt  = 1'b0;
        i_read = 1'b0;
        i_data = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.ready", o_ready, 1);
        chk("rst.empty", o_empty, 1);
        chk("rst.full",  o_full,  0);
        chk("rst.size",  o_size,  0);
        chk("rst.data",  o_data,  0);
        RST = 1'b0;

        op(1'b0, 1'b1, 0, 1'b0, "deq_empty");
        op(1'b1, 1'b1, 42, 1'b0, "rep_empty");
        chk("rep_empty.key", o_data, 42);
        op(1'b0, 1'b1, 0, 1'b0, "deq_last");

`ifndef BRAM_HEAP_MIN_ORDER_EN
        dir_keys = '{10, 300, 7, 1024, 55};
        dir_exp  = '{300, 55, 10, 7, 0};
        foreach (dir_keys[i]) op(1'b1, 1'b0, dir_keys[i], 1'b0, "dir_enq");
        chk("dir.top",  o_data, 1024);
        chk("dir.size", o_size, 5);
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 1'b1, 0, 1'b0, "dir_deq");
            chk("dir.order", o_data, dir_exp[i]);
        end
        chk("dir.drained", o_empty, 1);
`else
        dir_keys = '{9, 3, 3, 12, 0};
        dir_exp  = '{3, 9, 12, 0, 0};
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, dir_keys[i], 1'b0, "min_enq");
        chk("min.top", o_data, 3);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 0, 1'b0, "min_deq");
            chk("min.order", o_data, dir_exp[i]);
        end
`endif

        for (int i = 0; i < QS; i++) op(1'b1, 1'b0, $urandom_range(0, 1024), 1'b0, "fill");
        chk("fill.full", o_full, 1);
        op(1'b1, 1'b0, 2000, 1'b0, "enq_full");
        op(1'b1, 1'b1, 2000, 1'b0, "rep_full");
`ifndef BRAM_HEAP_MIN_ORDER_EN
        chk("rep_full.top", o_data, 2000);
`endif
        for (int i = 0; i < QS; i++)
            op(1'b1, 1'b1, $urandom_range(0, 1024), 1'($urandom_range(0, 1)), "rep_stream");
        for (int i = 0; i < QS; i++)
            op(1'b0, 1'b1, 0, 1'($urandom_range(0, 1)), "drain");

        for (int i = 0; i < 200; i++) begin
            cmd = $urandom_range(0, 4);
            case (cmd)
                0, 1:    op(1'b1, 1'b0, $urandom_range(0, 65535), 1'($urandom_range(0, 1)), "rnd_enq");
                2:       op(1'b0, 1'b1, 0, 1'($urandom_range(0, 1)), "rnd_deq");
                3:       op(1'b1, 1'b1, $urandom_range(0, 65535), 1'($urandom_range(0, 1)), "rnd_rep");
                default: op(1'b0, 1'b0, 0, 1'b0, "rnd_nop");
            endcase
        end

        op(1'b1, 1'b0, 5, 1'b0, "pre_rst");
        op(1'b1, 1'b0, 77, 1'b0, "pre_rst");
        i_read = 1'b1;
        @(posedge CLK);
        #1;
        i_read = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst.ready", o_ready, 1);
        chk("midrst.empty", o_empty, 1);
        chk("midrst.full",  o_full,  0);
        chk("midrst.size",  o_size,  0);
        chk("midrst.data",  o_data,  0);
        RST = 1'b0;
        mdl.delete();
        op(1'b1, 1'b0, 123, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bram_heap_pq.md
# bram_heap_pq

Parametrised BRAM-backed binary-heap priority queue, the successor to the fixed-size tree queue. One storage element per heap level: levels 0–1 in registers, levels ≥2 in inferred RAM holding sibling pairs. Supports enqueue, dequeue and replace with top-down insertion and sift-down, a ready handshake, and an occupancy count. It sits between a scheduler front end and the consumer that pops the highest-priority key.

## Interface
- `LEVELS`, default 4: heap depth. `QUEUE_SIZE = 2**LEVELS - 1`. Legal range is 2..16.
- `DATA_WIDTH`, default 16: key width, treated as unsigned.
- `CLK` in 1: single clock. All logic is rising-edge.
- `RST` in 1: reset, synchronous and active-high.
- `i_wrt` in 1: write request. Alone, it is an enqueue. Together with `i_read`, it is a replace.
- `i_read` in 1: read request. Alone, it is a dequeue.
- `i_data` in DATA_WIDTH: key for enqueue or replace.
- `o_ready` out 1: block idle. A command is accepted only on a rising edge where `o_ready=1`.
- `o_full` out 1: high when `o_size == QUEUE_SIZE`.
- `o_empty` out 1: high when `o_size == 0`.
- `o_data` out DATA_WIDTH: current root (top). Forced to 0 when empty.
- `o_size` out LEVELS: number of valid entries.

## Operation
- **Storage**
  - Level 0: root register.
  - Level 1: two registers.
  - Level l ≥ 2: RAM of depth 2^(l-1), word width 2·DATA_WIDTH, one word per sibling pair. Synchronous read with 1-cycle latency. One read port and one write port.
- **Heap property:** in max order (default), parent ≥ both children. Node k, 0-based and breadth-first, is valid iff k < `o_size`. An invalid child compares as −∞ (max order) or +∞ (min order).
- **Commands**, sampled when `o_ready=1`:
  - Enqueue (`i_wrt=1`, `i_read=0`), not full:
    - The target leaf is k = `o_size`. The path is taken from the bits of k+1.
    - At each level above the target: compare the carried key with the path node, write the winner to the node, and carry the loser down.
    - At the target level: write the carried key into the slot.
    - `o_size` increments.
  - Dequeue (`i_read=1`, `i_wrt=0`), not empty:
    - FETCH_LAST reads node `o_size-1`.
    - `o_size` decrements.
    - The fetched key is placed at the root, then sift-down runs.
  - Replace (both high):
    - Not empty: `i_data` goes to the root, then sift-down runs. `o_size` is unchanged.
    - Empty: treated as enqueue.
  - Ignored: dequeue when empty, enqueue when full, and any command while `o_ready=0`. An ignored command changes no state and leaves `o_ready` high.
- **Sift-down:** at each level, read the child pair and compare the parent with the better child. Swap if the child wins, and continue on the swapped path. Ties keep the parent (no swap).
- **FSM states:** IDLE, FETCH_LAST, RD, CMP.
  - IDLE →
    - FETCH_LAST on an accepted dequeue.
    - RD on an accepted enqueue or replace.
  - FETCH_LAST → RD.
  - RD → CMP.
  - CMP → RD for the next level, or → IDLE after level LEVELS-1.
  - There is no early termination: every op walks all levels, with no-op compares below the active node.
- **Reset:** abandons any in-flight op.
  - Reset values: `o_size=0`, `o_empty=1`, `o_full=0`, `o_data=0`, `o_ready=1`, FSM in IDLE.
  - RAM contents are not cleared; validity is governed by `o_size`.

## Timing
- `o_ready` falls the cycle after acceptance.
- Fixed busy time, from accept edge to the edge where `o_ready` is high again:
  - Enqueue and replace: 2·(LEVELS-1) cycles.
  - Dequeue: 2·(LEVELS-1)+1 cycles.
  - For LEVELS=4: 6 and 7 cycles.
- `o_size`, `o_empty` and `o_full` update on the accept edge.
- `o_data` is valid (final top) whenever `o_ready=1`. While busy, its value is undefined for checking purposes.
- Back-to-back: a new command may be accepted on the same edge that `o_ready` returns high.
- Key width: comparisons are unsigned, full DATA_WIDTH, with no truncation.

## Configuration
- `BRAM_HEAP_MIN_ORDER_EN`:
  - Defined: the heap is min-ordered. `o_data` is the smallest key, and invalid children compare as +∞.
  - Undefined (default): the heap is max-ordered. `o_data` is the largest key, and invalid children compare as −∞.
  - All timing and handshake behaviour is identical in both modes.

## Test plan
- **Reset:** assert `RST` for 2 cycles.
  - Expect `o_ready=1`, `o_empty=1`, `o_full=0`, `o_size=0`, `o_data=0`.
  - Reset again mid-op, 3 cycles into a dequeue: the same values are restored the next cycle.
- **Enqueue then dequeue:** LEVELS=4. Enqueue 10, 300, 7, 1024, 55, each after `o_ready`.
  - Expect `o_data=1024` and `o_size=5`.
  - Five dequeues then give `o_data` = 300, 55, 10, 7, then 0 with `o_empty=1`.
  - Each dequeue busy time is exactly 7 cycles.
- **Full boundary:** enqueue 15 random keys (0..1024).
  - Expect `o_full=1`.
  - A 16th enqueue of 2000 is ignored: `o_ready` stays high, and `o_size` and `o_data` are unchanged.
  - A replace with 2000 is accepted: `o_data=2000` after 6 cycles.
- **Replace stream:** queue full of known keys. Apply 15 replaces with random keys.
  - After each op, `o_data` equals the maximum of a reference model.
  - `o_size` stays 15.
- **Ignored commands:**
  - Dequeue when empty: no state change.
  - Replace when empty with 42: behaves as enqueue, giving `o_size=1` and `o_data=42`.
  - Any command pulsed while `o_ready=0`: dropped.
- **Min order:** with `BRAM_HEAP_MIN_ORDER_EN` defined, enqueue 9, 3, 3, 12.
  - Dequeue order is 3, 3, 9, 12.
  - The tie is handled without a spurious swap; the reference model matches after every op.
